// File: rtl/dbns_to_binary.sv
// Double-base (2^a * 3^b) digit-count operand to binary converter.
// Captures six weighted digit counts, accumulates one term per cycle, then holds the result for handoff.
module dbns_to_binary #(
   parameter int STORE_BITS  = 4,
   parameter int COUT_BITS   = 2,
   parameter int RESULT_BITS = 12
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [STORE_BITS-1:0]  store000,
   input  logic [STORE_BITS-1:0]  store001,
   input  logic [STORE_BITS-1:0]  store010,
   input  logic [STORE_BITS-1:0]  store100,
   input  logic [STORE_BITS-1:0]  store101,
   input  logic [STORE_BITS-1:0]  store110,
   input  logic [COUT_BITS-1:0]   cout1,
   input  logic [COUT_BITS-1:0]   cout2,
   input  logic [COUT_BITS-1:0]   cout3,
   input  logic [COUT_BITS-1:0]   cout4,
   input  logic [COUT_BITS-1:0]   cout5,
   input  logic [COUT_BITS-1:0]   cout6,
   output logic [RESULT_BITS-1:0] result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                         state_q;
   logic [2:0]                     idx_q;
   logic [5:0][STORE_BITS-1:0]     st_q;
   logic [5:0][COUT_BITS-1:0]      co_q;
   logic [RESULT_BITS-1:0]         acc_q, acc_d;
   logic [RESULT_BITS-1:0]         term_v, term_w;
   logic                           in_ready_q, out_valid_q, busy_q;

   // Unweighted term: carry sits directly above the digit count.
   always_comb begin
      term_v = '0;
      for (int i = 0; i < 6; i++) begin
         if (idx_q == 3'(i)) term_v = RESULT_BITS'({co_q[i], st_q[i]});
      end
   end

   // Weights 1,3,9,2,6,18 built from shifts and adds.
   always_comb begin
      term_w = '0;
      case (idx_q)
         3'd0:    term_w = term_v;
         3'd1:    term_w = (term_v << 1) + term_v;
         3'd2:    term_w = (term_v << 3) + term_v;
         3'd3:    term_w = term_v << 1;
         3'd4:    term_w = (term_v << 2) + (term_v << 1);
         3'd5:    term_w = (term_v << 4) + (term_v << 1);
         default: term_w = '0;
      endcase
   end

   assign acc_d = acc_q + term_w;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         st_q        <= '0;
         co_q        <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  st_q       <= {store110, store101, store100, store010, store001, store000};
                  co_q       <= {cout6, cout5, cout4, cout3, cout2, cout1};
                  acc_q      <= '0;
                  idx_q      <= '0;
                  state_q    <= ACCUM;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ACCUM: begin
               if (idx_q > 3'd5) begin
                  // Out-of-range index: abandon the operand rather than add garbage.
                  state_q    <= IDLE;
                  idx_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  idx_q <= idx_q + 3'd1;
                  if (idx_q == 3'd5) begin
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  idx_q       <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               idx_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign result    = acc_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dbns_to_binary.sv
// Scoreboard bench for dbns_to_binary: captures are snapshotted into a queue, a monitor checks results.
module tb_dbns_to_binary;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, busy;
   logic [11:0] result;
   logic [3:0]  st [6];
   logic [1:0]  co [6];

   typedef struct {int exp; int cap;} item_t;
   item_t sb[$];

   int  n_chk = 0, n_fail = 0, cyc = 0, last_cap = 0;
   bit  cont = 1'b0, last_ok = 1'b0, prev_ov = 1'b0;
   int  w [6] = '{1, 3, 9, 2, 6, 18};

   always #5 clock = ~clock;

   dbns_to_binary #(.STORE_BITS(4), .COUT_BITS(2), .RESULT_BITS(12)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .store000(st[0]), .store001(st[1]), .store010(st[2]),
      .store100(st[3]), .store101(st[4]), .store110(st[5]),
      .cout1(co[0]), .cout2(co[1]), .cout3(co[2]),
      .cout4(co[3]), .cout5(co[4]), .cout6(co[5]),
      .result(result), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   // Reference: sum of (carry*16 + count) * 2^x * 3^y over the six digit positions.
   function automatic int model();
      int s = 0;
      for (int i = 0; i < 6; i++) s += (int'(co[i]) * 16 + int'(st[i])) * w[i];
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < 6; i++) begin
         st[i] = 4'($urandom);
         co[i] = 2'($urandom);
      end
   endtask

   task automatic clear_ops();
      for (int i = 0; i < 6; i++) begin
         st[i] = '0;
         co[i] = '0;
      end
   endtask

   // Capture snapshot: the operand present at an accepting edge becomes the expected result.
   always @(posedge clock) begin
      cyc++;
      if (reset_n && in_valid && in_ready) begin
         if (cont && last_ok) chk("throughput_spacing", cyc - last_cap, 8);
         sb.push_back('{model(), cyc});
         last_cap = cyc;
         last_ok  = 1'b1;
      end
   end

   // Monitor: latency on out_valid rise, result compare on handshake.
   always @(negedge clock) begin
      if (reset_n) begin
         if (out_valid && !prev_ov) begin
            chk("out_valid_has_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("latency", cyc - sb[0].cap, 6);
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            chk("result", int'(result), it.exp);
         end
         prev_ov = out_valid;
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic send();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      chk("in_ready_before_send", int'(in_ready), 1);
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("busy_after_capture", int'(busy), 1);
      chk("in_ready_after_capture", int'(in_ready), 0);
      scramble();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(sb.size() == 0 && in_ready) && n < 100) begin
         @(posedge clock); #2;
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      int e, n;
      clear_ops();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_result", int'(result), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      reset_n   = 1'b1;
      out_ready = 1'b1;

      // Directed values
      clear_ops(); send(); wait_idle();
      clear_ops(); st[0] = 4'd1; st[2] = 4'd2; co[2] = 2'd1; send(); wait_idle();
      for (int i = 0; i < 6; i++) begin st[i] = 4'd15; co[i] = 2'd3; end
      send(); wait_idle();
      clear_ops(); st[5] = 4'd15; co[5] = 2'd3; send(); wait_idle();

      // Stall in DONE with inputs churning
      out_ready = 1'b0;
      scramble();
      e = model();
      send();
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clock); #1; n++; end
      chk("done_out_valid", int'(out_valid), 1);
      repeat (5) begin
         scramble();
         in_valid = 1'($urandom);
         @(posedge clock); #1;
         chk("hold_result", int'(result), e);
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      chk("release_out_valid", int'(out_valid), 0);
      chk("release_in_ready", int'(in_ready), 1);
      chk("release_result_kept", int'(result), e);
      wait_idle();

      // Reset at the third accumulate edge
      scramble();
      send();
      repeat (2) @(posedge clock);
      @(posedge clock); #1;
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("abort_result", int'(result), 0);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      @(posedge clock); #1;
      reset_n = 1'b1;
      clear_ops(); st[4] = 4'd1;
      send(); wait_idle();

      // Continuous in_valid with operands changing every cycle
      last_ok  = 1'b0;
      cont     = 1'b1;
      in_valid = 1'b1;
      repeat (88) begin
         scramble();
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      cont     = 1'b0;
      wait_idle();

      // Random operands with random downstream stalls
      repeat (6) begin
         scramble();
         out_ready = 1'($urandom);
         send();
         repeat ($urandom_range(6, 12)) begin
            @(posedge clock); #1;
            out_ready = 1'($urandom);
         end
         out_ready = 1'b1;
         wait_idle();
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
